// File: rtl/i2c_pkg.sv
// Shared encodings for the I2C bit sequencer: bus commands, phase states and
// the per-command SCL/SDA enable pattern for each of the four phases.
package i2c_pkg;

  typedef enum logic [1:0] {
    CMD_START = 2'b00,
    CMD_STOP  = 2'b01,
    CMD_WRITE = 2'b10,
    CMD_READ  = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PH_A = 3'd1,
    PH_B = 3'd2,
    PH_C = 3'd3,
    PH_D = 3'd4
  } phase_e;

  // Output-enable patterns, bit 3 = phase A down to bit 0 = phase D (1 = released).
  localparam logic [3:0] START_SCL = 4'b1110;
  localparam logic [3:0] START_SDA = 4'b1100;
  localparam logic [3:0] STOP_SCL  = 4'b0111;
  localparam logic [3:0] STOP_SDA  = 4'b0001;
  localparam logic [3:0] WRITE_SCL = 4'b0110;
  localparam logic [3:0] READ_SCL  = 4'b0110;
  localparam logic [3:0] READ_SDA  = 4'b1111;

  // Returns {scl_oen, sda_oen} for command c in phase ph; WRITE drives din on SDA.
  function automatic logic [1:0] phase_lines(input cmd_e c, input phase_e ph, input logic d);
    logic [3:0] scl_pat;
    logic [3:0] sda_pat;
    logic [1:0] idx;
    scl_pat = 4'b1111;
    sda_pat = 4'b1111;
    idx     = 2'd0;
    case (c)
      CMD_START: begin scl_pat = START_SCL; sda_pat = START_SDA; end
      CMD_STOP:  begin scl_pat = STOP_SCL;  sda_pat = STOP_SDA;  end
      CMD_WRITE: begin scl_pat = WRITE_SCL; sda_pat = {4{d}};    end
      default:   begin scl_pat = READ_SCL;  sda_pat = READ_SDA;  end
    endcase
    case (ph)
      PH_A:    idx = 2'd3;
      PH_B:    idx = 2'd2;
      PH_C:    idx = 2'd1;
      default: idx = 2'd0;
    endcase
    return {scl_pat[idx], sda_pat[idx]};
  endfunction

endpackage

// File: rtl/i2c_clkcnt.sv
// Loadable down counter that times one I2C phase; tci flags the terminal value.
// Decrement below minval reloads maxval, but the sequencer reloads before that.
module i2c_clkcnt #(
  parameter int W            = 6,
  parameter int areset_value = 0,
  parameter int minval       = 0,
  parameter int maxval       = 63
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         load,
  input  logic         cen,
  input  logic [W-1:0] d,
  output logic         tci
);

  localparam logic [W-1:0] RST_V = W'(areset_value);
  localparam logic [W-1:0] MIN_V = W'(minval);
  localparam logic [W-1:0] MAX_V = W'(maxval);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt_q <= RST_V;
    end else if (load) begin
      cnt_q <= d;
    end else if (cen) begin
      cnt_q <= (cnt_q == MIN_V) ? MAX_V : cnt_q - 1'b1;
    end
  end

  assign tci = (cnt_q == MIN_V);

endmodule

// File: rtl/i2c_bitctrl.sv
// Bit-level I2C master: sequences one START/STOP/WRITE/READ command through
// four timed phases, with clock stretching and arbitration-loss detection.
//   state | meaning
//   IDLE  | waiting for a command, lines hold last driven value
//   PH_A  | first quarter of the bit
//   PH_B  | second quarter, SCL usually released
//   PH_C  | third quarter, SDA sampled / arbitration checked at its end
//   PH_D  | last quarter, completion at its end
module i2c_bitctrl
  import i2c_pkg::*;
#(
  parameter logic [5:0] PRESCALE_RST = 6'd0,
  parameter int         SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [5:0] prescale,
  input  logic       cmd_valid,
  input  logic [1:0] cmd,
  input  logic       din,
  output logic       cmd_ready,
  output logic       cmd_ack,
  output logic       dout,
  output logic       al,
  output logic       busy,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_oen,
  output logic       sda_oen
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_s;
  logic                   sda_s;

  phase_e state_q, state_d;
  cmd_e   cmd_q, cmd_d;
  logic   din_q, din_d;
  logic   scl_oen_q, scl_oen_d;
  logic   sda_oen_q, sda_oen_d;
  logic   ack_q, ack_d;
  logic   al_q, al_d;
  logic   dout_q, dout_d;
  logic   busy_q, busy_d;

  logic   load;
  logic   cnt_cen;
  logic   cnt_tci;
  logic   tc;
  logic   arb_lost;
  logic   done;
  logic   rst_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
    end
  end

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  // Freeze while we release SCL but a slave still holds it low.
  assign cnt_cen = (state_q != IDLE) & ~(scl_oen_q & ~scl_s);
  assign tc      = cnt_tci & cnt_cen;
  assign rst_b   = ~rst;

  i2c_clkcnt #(
    .W            (6),
    .areset_value (int'(PRESCALE_RST)),
    .minval       (0),
    .maxval       (63)
  ) u_clkcnt (
    .clk   (clk),
    .rst_b (rst_b),
    .load  (load),
    .cen   (cnt_cen & ~cnt_tci),
    .d     (prescale),
    .tci   (cnt_tci)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cmd_q     <= CMD_START;
      din_q     <= 1'b0;
      scl_oen_q <= 1'b1;
      sda_oen_q <= 1'b1;
      ack_q     <= 1'b0;
      al_q      <= 1'b0;
      dout_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      din_q     <= din_d;
      scl_oen_q <= scl_oen_d;
      sda_oen_q <= sda_oen_d;
      ack_q     <= ack_d;
      al_q      <= al_d;
      dout_q    <= dout_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    din_d    = din_q;
    load     = 1'b0;
    arb_lost = 1'b0;
    done     = 1'b0;
    if (!ena) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            state_d = PH_A;
            cmd_d   = cmd_e'(cmd);
            din_d   = din;
            load    = 1'b1;
          end
        end
        PH_A: begin
          if (tc) begin
            state_d = PH_B;
            load    = 1'b1;
          end
        end
        PH_B: begin
          if (tc) begin
            if (cmd_q == CMD_START && !sda_s) begin
              arb_lost = 1'b1;
              state_d  = IDLE;
            end else begin
              state_d = PH_C;
              load    = 1'b1;
            end
          end
        end
        PH_C: begin
          if (tc) begin
            if (cmd_q == CMD_WRITE && din_q && !sda_s) begin
              arb_lost = 1'b1;
              state_d  = IDLE;
            end else begin
              state_d = PH_D;
              load    = 1'b1;
            end
          end
        end
        PH_D: begin
          if (tc) begin
            state_d = IDLE;
            done    = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    scl_oen_d = scl_oen_q;
    sda_oen_d = sda_oen_q;
    ack_d     = 1'b0;
    al_d      = 1'b0;
    dout_d    = dout_q;
    busy_d    = busy_q;
    if (!ena || arb_lost) begin
      scl_oen_d = 1'b1;
      sda_oen_d = 1'b1;
      busy_d    = 1'b0;
      al_d      = arb_lost;
    end else begin
      if (load) begin
        {scl_oen_d, sda_oen_d} = phase_lines(cmd_d, state_d, din_d);
      end
      if (done) begin
        ack_d = 1'b1;
        if (cmd_q == CMD_START) begin
          busy_d = 1'b1;
        end else if (cmd_q == CMD_STOP) begin
          busy_d = 1'b0;
        end
      end
      if (state_q == PH_C && tc && cmd_q == CMD_READ) begin
        dout_d = sda_s;
      end
    end
  end

  assign cmd_ready = (state_q == IDLE) & ena;
  assign cmd_ack   = ack_q;
  assign al        = al_q;
  assign dout      = dout_q;
  assign busy      = busy_q;
  assign scl_oen   = scl_oen_q;
  assign sda_oen   = sda_oen_q;

endmodule

// File: tb/tb_i2c_bitctrl.sv
// Self-checking bench for i2c_bitctrl: a command table plus hand sequences for
// stretching, back-to-back transfers and aborts, with a completion scoreboard.
module tb_i2c_bitctrl;

  localparam logic [1:0] C_START = 2'b00;
  localparam logic [1:0] C_STOP  = 2'b01;
  localparam logic [1:0] C_WRITE = 2'b10;
  localparam logic [1:0] C_READ  = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ena = 1'b1;
  logic [5:0] prescale = 6'd0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd = 2'b00;
  logic       din = 1'b0;
  logic       scl_i = 1'b1;
  logic       sda_i = 1'b1;
  logic       cmd_ready, cmd_ack, dout, al, busy, scl_oen, sda_oen;

  i2c_bitctrl dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .prescale  (prescale),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .din       (din),
    .cmd_ready (cmd_ready),
    .cmd_ack   (cmd_ack),
    .dout      (dout),
    .al        (al),
    .busy      (busy),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .scl_oen   (scl_oen),
    .sda_oen   (sda_oen)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lat;
    bit is_al;
    bit chk_dout;
    bit dout;
    bit busy;
  } exp_t;

  typedef struct {
    logic [1:0] c;
    logic       d;
    logic       sda;
    logic [5:0] p;
    bit         al;
    bit         chk_dout;
    bit         dout;
  } vec_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_xfer = 0;
  bit   exp_busy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Scoreboard: every ack/al event pops one expectation.
  always @(negedge clk) begin
    if (!rst && (cmd_ack || al)) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event actual=ack%0b_al%0b required=none (t=%0t)", cmd_ack, al, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("event_latency", cyc - last_xfer, mon_e.lat);
        chk("event_ack", cmd_ack, !mon_e.is_al);
        chk("event_al", al, mon_e.is_al);
        chk("event_busy", busy, mon_e.busy);
        if (mon_e.chk_dout) chk("read_dout", dout, mon_e.dout);
        if (mon_e.is_al) begin
          chk("al_scl_release", scl_oen, 1);
          chk("al_sda_release", sda_oen, 1);
          chk("al_cmd_ready", cmd_ready, 1);
        end
      end
    end
    if (cmd_valid && cmd_ready) last_xfer = cyc + 1;
  end

  function automatic logic [1:0] exp_lines(input logic [1:0] c, input int ph, input logic d);
    case (c)
      C_START: case (ph) 0: return 2'b11; 1: return 2'b11; 2: return 2'b10; default: return 2'b00; endcase
      C_STOP:  case (ph) 0: return 2'b00; 1: return 2'b10; 2: return 2'b10; default: return 2'b11; endcase
      C_WRITE: case (ph) 0: return {1'b0, d}; 1: return {1'b1, d}; 2: return {1'b1, d}; default: return {1'b0, d}; endcase
      default: case (ph) 0: return 2'b01; 1: return 2'b11; 2: return 2'b11; default: return 2'b01; endcase
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns just after the transfer edge.
  task automatic start_cmd(input logic [1:0] c, input logic d, input logic [5:0] p,
                           input bit push, input exp_t e);
    int n;
    n = 0;
    prescale = p;
    cmd = c;
    din = d;
    while (!cmd_ready && n < 100) begin
      tick();
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout actual=0 required=1");
    end
    cmd_valid = 1'b1;
    if (push) exp_q.push_back(e);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL event_timeout actual=%0d_pending required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  function automatic exp_t mk_exp(input int lat, input bit is_al, input bit chk_dout,
                                  input bit d, input bit b);
    exp_t e;
    e.lat = lat;
    e.is_al = is_al;
    e.chk_dout = chk_dout;
    e.dout = d;
    e.busy = b;
    return e;
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  vec_t vecs[12];
  vec_t v;
  exp_t e;
  int   n_x;
  int   guard;

  initial begin
    //        cmd      din   sda   pre   al    chkd  dout
    vecs[0]  = '{C_START, 1'b0, 1'b1, 6'd3, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{C_STOP,  1'b0, 1'b1, 6'd3, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{C_START, 1'b0, 1'b1, 6'd1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{C_WRITE, 1'b0, 1'b1, 6'd1, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{C_READ,  1'b0, 1'b1, 6'd1, 1'b0, 1'b1, 1'b1};
    vecs[5]  = '{C_READ,  1'b0, 1'b0, 6'd1, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{C_WRITE, 1'b1, 1'b1, 6'd2, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{C_WRITE, 1'b1, 1'b0, 6'd2, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{C_START, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{C_START, 1'b0, 1'b1, 6'd5, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{C_READ,  1'b0, 1'b1, 6'd5, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{C_STOP,  1'b0, 1'b1, 6'd0, 1'b0, 1'b0, 1'b0};

    #1 rst = 1'b1;
    tick();
    tick();
    chk("rst_scl_oen", scl_oen, 1);
    chk("rst_sda_oen", sda_oen, 1);
    chk("rst_cmd_ack", cmd_ack, 0);
    chk("rst_al", al, 0);
    chk("rst_dout", dout, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    tick();
    chk("rst_cmd_ready", cmd_ready, 1);

    for (int i = 0; i < 12; i++) begin
      v = vecs[i];
      sda_i = v.sda;
      if (v.al) exp_busy = 1'b0;
      else if (v.c == C_START) exp_busy = 1'b1;
      else if (v.c == C_STOP) exp_busy = 1'b0;
      e = mk_exp(v.al ? ((v.c == C_START) ? 2 : 3) * (int'(v.p) + 1) : 4 * (int'(v.p) + 1),
                 v.al, v.chk_dout, v.dout, exp_busy);
      start_cmd(v.c, v.d, v.p, 1'b1, e);
      if (!v.al) begin
        for (int ph = 0; ph < 4; ph++) begin
          if (ph > 0) repeat (int'(v.p) + 1) tick();
          chk($sformatf("vec%0d_ph%0d_lines", i, ph), {scl_oen, sda_oen}, exp_lines(v.c, ph, v.d));
        end
      end
      wait_drain();
    end

    // Clock stretch: slave holds SCL low for 10 cycles during phase B.
    sda_i = 1'b1;
    start_cmd(C_WRITE, 1'b0, 6'd2, 1'b1, mk_exp(12 + 10, 1'b0, 1'b0, 1'b0, exp_busy));
    repeat (3) tick();
    chk("stretch_phB_lines", {scl_oen, sda_oen}, 2'b10);
    scl_i = 1'b0;
    repeat (10) tick();
    scl_i = 1'b1;
    chk("stretch_held_lines", {scl_oen, sda_oen}, 2'b10);
    wait_drain();

    // Back-to-back: four WRITEs with cmd_valid held high.
    prescale = 6'd0;
    cmd = C_WRITE;
    din = 1'b0;
    cmd_valid = 1'b1;
    n_x = 0;
    guard = 0;
    while (n_x < 4 && guard < 100) begin
      if (cmd_ready) begin
        if (n_x > 0) chk($sformatf("b2b_xfer%0d_in_ack_cycle", n_x), cmd_ack, 1);
        exp_q.push_back(mk_exp(4, 1'b0, 1'b0, 1'b0, exp_busy));
        n_x++;
      end
      tick();
      guard++;
      din = n_x[0];
    end
    cmd_valid = 1'b0;
    chk("b2b_transfers", n_x, 4);
    wait_drain();

    // ena dropped in phase B of a READ.
    start_cmd(C_READ, 1'b0, 6'd3, 1'b0, e);
    repeat (4) tick();
    chk("ena_abort_phB_lines", {scl_oen, sda_oen}, 2'b11);
    ena = 1'b0;
    tick();
    chk("ena_abort_scl", scl_oen, 1);
    chk("ena_abort_sda", sda_oen, 1);
    chk("ena_abort_ready", cmd_ready, 0);
    ena = 1'b1;
    #1;
    chk("ena_restore_ready", cmd_ready, 1);
    repeat (20) tick();
    start_cmd(C_READ, 1'b0, 6'd1, 1'b1, mk_exp(8, 1'b0, 1'b1, 1'b1, 1'b0));
    wait_drain();

    // rst pulsed in phase B of a READ; dout was 1 beforehand.
    start_cmd(C_READ, 1'b0, 6'd3, 1'b0, e);
    repeat (4) tick();
    rst = 1'b1;
    #1;
    chk("rst_abort_scl", scl_oen, 1);
    chk("rst_abort_sda", sda_oen, 1);
    chk("rst_abort_dout", dout, 0);
    chk("rst_abort_ack", cmd_ack, 0);
    chk("rst_abort_busy", busy, 0);
    tick();
    rst = 1'b0;
    repeat (10) tick();
    start_cmd(C_START, 1'b0, 6'd1, 1'b1, mk_exp(8, 1'b0, 1'b0, 1'b0, 1'b1));
    wait_drain();
    start_cmd(C_STOP, 1'b0, 6'd0, 1'b1, mk_exp(4, 1'b0, 1'b0, 1'b0, 1'b0));
    wait_drain();
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
